// File: rtl/exe_module.sv
// Execute stage: Val2 generation, ALU with NZCV flags, branch target, status register
// and the EXE/MEM pipeline register.
module exe_module (
   input  logic        clk,
   input  logic        rst,
   input  logic        WB_EN_IN,
   input  logic        MEM_R_EN_IN,
   input  logic        MEM_W_EN_IN,
   input  logic        B,
   input  logic        S,
   input  logic [3:0]  EXE_CMD,
   input  logic [31:0] PC,
   input  logic [31:0] Val_Rn,
   input  logic [31:0] Val_Rm,
   input  logic        imm,
   input  logic [11:0] Shift_operand,
   input  logic [23:0] Signed_imm_24,
   input  logic [3:0]  Dest_IN,
   output logic        WB_EN,
   output logic        MEM_R_EN,
   output logic        MEM_W_EN,
   output logic [31:0] ALU_Res,
   output logic [31:0] Val_Rm_OUT,
   output logic [3:0]  Dest,
   output logic [3:0]  SR,
   output logic        Branch_Taken,
   output logic [31:0] Branch_Address
);

   typedef enum logic [3:0] {
      CMD_MOV = 4'b0001,
      CMD_MVN = 4'b1001,
      CMD_ADD = 4'b0010,
      CMD_ADC = 4'b0011,
      CMD_SUB = 4'b0100,
      CMD_SBC = 4'b0101,
      CMD_AND = 4'b0110,
      CMD_ORR = 4'b0111,
      CMD_EOR = 4'b1000
   } exe_cmd_e;

   logic        r_wb_en, r_mem_r_en, r_mem_w_en;
   logic [31:0] r_alu_res, r_val_rm;
   logic [3:0]  r_dest, r_sr;

   logic [4:0]  w_shamt;
   logic [63:0] w_rm_ror64, w_imm_ror64;
   logic [31:0] w_shifted, w_val2, w_alu_res;
   logic [32:0] w_sum;
   logic        w_cin, w_c, w_v;

   // Rotates done as a right shift of a doubled word; the low half is the rotated value.
   assign w_shamt     = Shift_operand[11:7];
   assign w_rm_ror64  = {Val_Rm, Val_Rm} >> w_shamt;
   assign w_imm_ror64 = {24'b0, Shift_operand[7:0], 24'b0, Shift_operand[7:0]}
                        >> {Shift_operand[11:8], 1'b0};

   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      w_shifted = Val_Rm;
      case (Shift_operand[6:5])
         2'b00:   w_shifted = Val_Rm << w_shamt;
         2'b01:   w_shifted = Val_Rm >> w_shamt;
         2'b10:   w_shifted = $unsigned($signed(Val_Rm) >>> w_shamt);
         default: w_shifted = w_rm_ror64[31:0];
      endcase
   end

   always_comb begin
      w_val2 = w_shifted;
      if (MEM_R_EN_IN || MEM_W_EN_IN) w_val2 = {20'b0, Shift_operand};
      else if (imm)                   w_val2 = w_imm_ror64[31:0];
   end

   assign w_cin = r_sr[1];

   // Logic and move ops leave C and V as they were.
   always_comb begin
      w_sum     = '0;
      w_alu_res = '0;
      w_c       = r_sr[1];
      w_v       = r_sr[0];
      case (EXE_CMD)
         CMD_MOV: w_alu_res = w_val2;
         CMD_MVN: w_alu_res = ~w_val2;
         CMD_AND: w_alu_res = Val_Rn & w_val2;
         CMD_ORR: w_alu_res = Val_Rn | w_val2;
         CMD_EOR: w_alu_res = Val_Rn ^ w_val2;
         CMD_ADD, CMD_ADC: begin
            w_sum     = {1'b0, Val_Rn} + {1'b0, w_val2}
                        + {32'b0, (EXE_CMD == CMD_ADC) && w_cin};
            w_alu_res = w_sum[31:0];
            w_c       = w_sum[32];
            w_v       = (Val_Rn[31] == w_val2[31]) && (w_sum[31] != Val_Rn[31]);
         end
         CMD_SUB, CMD_SBC: begin
            w_sum     = {1'b0, Val_Rn} - {1'b0, w_val2}
                        - {32'b0, (EXE_CMD == CMD_SBC) && !w_cin};
            w_alu_res = w_sum[31:0];
            w_c       = ~w_sum[32];
            w_v       = (Val_Rn[31] != w_val2[31]) && (w_sum[31] != Val_Rn[31]);
         end
         default: w_alu_res = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: all state updates use non-blocking assignments.
      if (rst) begin
         r_wb_en    <= 1'b0;
         r_mem_r_en <= 1'b0;
         r_mem_w_en <= 1'b0;
         r_alu_res  <= '0;
         r_val_rm   <= '0;
         r_dest     <= '0;
         r_sr       <= '0;
      end else begin
         r_wb_en    <= WB_EN_IN;
         r_mem_r_en <= MEM_R_EN_IN;
         r_mem_w_en <= MEM_W_EN_IN;
         r_alu_res  <= w_alu_res;
         r_val_rm   <= Val_Rm;
         r_dest     <= Dest_IN;
         if (S) r_sr <= {w_alu_res[31], (w_alu_res == 32'b0), w_c, w_v};
      end
   end

   assign WB_EN          = r_wb_en;
   assign MEM_R_EN       = r_mem_r_en;
   assign MEM_W_EN       = r_mem_w_en;
   assign ALU_Res        = r_alu_res;
   assign Val_Rm_OUT     = r_val_rm;
   assign Dest           = r_dest;
   assign SR             = r_sr;
   assign Branch_Taken   = B;
   assign Branch_Address = PC + {{6{Signed_imm_24[23]}}, Signed_imm_24, 2'b00};

endmodule

// File: tb/tb_exe_module.sv
// Self-checking bench for exe_module: directed instructions with a scoreboard queue
// of expected EXE/MEM register contents, plus same-cycle branch checks.
module tb_exe_module;

   logic        clk = 1'b0;
   logic        rst;
   logic        WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN, B, S, imm;
   logic [3:0]  EXE_CMD, Dest_IN;
   logic [31:0] PC, Val_Rn, Val_Rm;
   logic [11:0] Shift_operand;
   logic [23:0] Signed_imm_24;
   logic        WB_EN, MEM_R_EN, MEM_W_EN, Branch_Taken;
   logic [31:0] ALU_Res, Val_Rm_OUT, Branch_Address;
   logic [3:0]  Dest, SR;

   typedef struct {
      string       tag;
      logic [31:0] alu;
      logic [3:0]  sr;
      logic [2:0]  ctl;
      logic [3:0]  dest;
      logic [31:0] rm;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   localparam logic [3:0] MOV = 4'b0001, MVN = 4'b1001, ADD = 4'b0010, ADC = 4'b0011,
                          SUB = 4'b0100, SBC = 4'b0101, AND = 4'b0110, ORR = 4'b0111,
                          EOR = 4'b1000, UND = 4'b1111;

   exe_module dut (
      .clk(clk), .rst(rst),
      .WB_EN_IN(WB_EN_IN), .MEM_R_EN_IN(MEM_R_EN_IN), .MEM_W_EN_IN(MEM_W_EN_IN),
      .B(B), .S(S), .EXE_CMD(EXE_CMD), .PC(PC), .Val_Rn(Val_Rn), .Val_Rm(Val_Rm),
      .imm(imm), .Shift_operand(Shift_operand), .Signed_imm_24(Signed_imm_24),
      .Dest_IN(Dest_IN),
      .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .ALU_Res(ALU_Res),
      .Val_Rm_OUT(Val_Rm_OUT), .Dest(Dest), .SR(SR),
      .Branch_Taken(Branch_Taken), .Branch_Address(Branch_Address)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
      end
   endtask

   // Drives one instruction, pushes its expected EXE/MEM contents, then compares after the edge.
   task automatic issue(input string tag, input bit rst_v, input logic [3:0] cmd, input bit s_v,
                        input logic [31:0] rn, input logic [31:0] rm, input bit imm_v,
                        input logic [11:0] shop, input bit wb, input bit mr, input bit mw,
                        input logic [3:0] dst, input logic [31:0] exp_alu,
                        input logic [3:0] exp_sr);
      exp_t e, got_e;
      rst = rst_v; EXE_CMD = cmd; S = s_v; Val_Rn = rn; Val_Rm = rm; imm = imm_v;
      Shift_operand = shop; WB_EN_IN = wb; MEM_R_EN_IN = mr; MEM_W_EN_IN = mw; Dest_IN = dst;
      e.tag = tag;
      if (rst_v) begin
         e.alu = '0; e.sr = '0; e.ctl = '0; e.dest = '0; e.rm = '0;
      end else begin
         e.alu = exp_alu; e.sr = exp_sr; e.ctl = {wb, mr, mw}; e.dest = dst; e.rm = rm;
      end
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      check({tag, "_sbq"}, 32'(sb_q.size()), 32'd1);
      if (sb_q.size() != 0) begin
         got_e = sb_q.pop_front();
         check({got_e.tag, "_alu"},  ALU_Res, got_e.alu);
         check({got_e.tag, "_sr"},   {28'b0, SR}, {28'b0, got_e.sr});
         check({got_e.tag, "_ctl"},  {29'b0, WB_EN, MEM_R_EN, MEM_W_EN}, {29'b0, got_e.ctl});
         check({got_e.tag, "_dest"}, {28'b0, Dest}, {28'b0, got_e.dest});
         check({got_e.tag, "_rm"},   Val_Rm_OUT, got_e.rm);
      end
   endtask

   task automatic br(input string tag, input logic [31:0] pc, input logic [23:0] off,
                     input logic [31:0] exp_addr);
      B = 1'b1; PC = pc; Signed_imm_24 = off;
      #1;
      check({tag, "_taken"}, {31'b0, Branch_Taken}, 32'd1);
      check({tag, "_addr"}, Branch_Address, exp_addr);
      B = 1'b0;
      #1;
      check({tag, "_nottaken"}, {31'b0, Branch_Taken}, 32'd0);
   endtask

   initial begin
      rst = 1'b1; WB_EN_IN = 1'b1; MEM_R_EN_IN = 1'b0; MEM_W_EN_IN = 1'b1; B = 1'b0; S = 1'b1;
      imm = 1'b1; EXE_CMD = ADD; Dest_IN = 4'hA; PC = 32'h1000; Val_Rn = 32'h5555_AAAA;
      Val_Rm = 32'hCAFE_F00D; Shift_operand = 12'h3C5; Signed_imm_24 = 24'h000010;
      #2;

      issue("reset0", 1, ADD, 1, 32'hFFFF_FFFF, 32'h1234_5678, 1, 12'h0FF, 1, 1, 1, 4'hF, 0, 0);
      issue("reset1", 1, SUB, 1, 32'h0000_0001, 32'h8765_4321, 0, 12'h123, 1, 0, 1, 4'h7, 0, 0);

      issue("adds_ovf", 0, ADD, 1, 32'h7FFF_FFFF, 32'h1234_5678, 1, 12'h001, 1, 0, 0, 4'h3,
            32'h8000_0000, 4'b1001);
      issue("cmp_eq",   0, SUB, 1, 32'd5, 32'd0, 1, 12'h005, 0, 0, 0, 4'h0, 32'd0, 4'b0110);
      issue("adc_cin1", 0, ADC, 0, 32'd1, 32'd0, 1, 12'h001, 1, 0, 0, 4'h1, 32'd3, 4'b0110);
      issue("subs_neg", 0, SUB, 1, 32'd3, 32'd0, 1, 12'h00A, 1, 0, 0, 4'h2,
            32'hFFFF_FFF9, 4'b1000);
      issue("sbcs_c0",  0, SBC, 1, 32'd10, 32'd0, 1, 12'h003, 1, 0, 0, 4'h2, 32'd6, 4'b0010);

      br("br_back", 32'h0000_0040, 24'hFFFFFE, 32'h0000_0038);

      issue("asr4",     0, MOV, 0, 32'd0, 32'h8000_0000, 0, 12'h240, 1, 0, 0, 4'h4,
            32'hF800_0000, 4'b0010);
      issue("rot_imm",  0, MOV, 0, 32'd0, 32'h0000_0000, 1, 12'h4FF, 1, 0, 0, 4'h5,
            32'hFF00_0000, 4'b0010);
      issue("lsl4",     0, ADD, 0, 32'd1, 32'h0000_000F, 0, 12'h200, 1, 0, 0, 4'h6,
            32'h0000_00F1, 4'b0010);
      issue("lsr4",     0, MOV, 0, 32'd0, 32'h8000_0000, 0, 12'h220, 1, 0, 0, 4'h7,
            32'h0800_0000, 4'b0010);
      issue("ror4",     0, MOV, 0, 32'd0, 32'h0000_000F, 0, 12'h260, 1, 0, 0, 4'h8,
            32'hF000_0000, 4'b0010);
      issue("asr0",     0, MOV, 0, 32'd0, 32'h8000_0001, 0, 12'h040, 1, 0, 0, 4'h9,
            32'h8000_0001, 4'b0010);

      br("br_fwd", 32'h0000_0040, 24'h000003, 32'h0000_004C);

      issue("adds_cv",  0, ADD, 1, 32'h8000_0000, 32'd0, 1, 12'h102, 1, 0, 0, 4'hA,
            32'h0000_0000, 4'b0111);
      issue("und_keep", 0, UND, 1, 32'h1234_5678, 32'd0, 1, 12'h0AA, 1, 0, 0, 4'hB,
            32'h0000_0000, 4'b0111);
      issue("mvns",     0, MVN, 1, 32'd0, 32'd0, 1, 12'h000, 1, 0, 0, 4'hC,
            32'hFFFF_FFFF, 4'b1011);
      issue("ands_z",   0, AND, 1, 32'h0000_00F0, 32'd0, 1, 12'h00F, 0, 0, 0, 4'h0,
            32'h0000_0000, 4'b0111);
      issue("orr",      0, ORR, 0, 32'h0000_00F0, 32'd0, 1, 12'h00F, 1, 0, 0, 4'hD,
            32'h0000_00FF, 4'b0111);
      issue("eor",      0, EOR, 0, 32'h0000_00FF, 32'd0, 1, 12'h00F, 1, 0, 0, 4'hE,
            32'h0000_00F0, 4'b0111);
      issue("sbc_cin1", 0, SBC, 0, 32'd10, 32'd0, 1, 12'h003, 1, 0, 0, 4'h1, 32'd7, 4'b0111);
      issue("ldr_off",  0, ADD, 0, 32'h0000_0100, 32'h0000_0000, 0, 12'h804, 1, 1, 0, 4'h2,
            32'h0000_0904, 4'b0111);
      issue("str_off",  0, ADD, 0, 32'h0000_0200, 32'hDEAD_BEEF, 1, 12'h010, 0, 0, 1, 4'h3,
            32'h0000_0210, 4'b0111);
      issue("rst_mid",  1, ADD, 1, 32'h7FFF_FFFF, 32'h1111_2222, 1, 12'h001, 1, 1, 0, 4'h4,
            32'h8000_0000, 4'b1001);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
